// File: rtl/matrix_wb_arbiter_if.sv
// Wishbone pipelined bus bundle between the requesting masters, the arbiter
// and the matrix register slave; master k occupies slice k of each packed field.
interface matrix_wb_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 3,
  parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
);
  logic [NUM_MASTERS-1:0]               i_m_cyc;
  logic [NUM_MASTERS-1:0]               i_m_stb;
  logic [NUM_MASTERS-1:0]               i_m_we;
  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] i_m_addr;
  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  i_m_sel;
  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] i_m_wdata;
  logic [NUM_MASTERS-1:0]               o_m_ack;
  logic [NUM_MASTERS-1:0]               o_m_stall;
  logic [WB_DATA_WIDTH-1:0]             o_m_rdata;

  logic                                 o_wb_cyc;
  logic                                 o_wb_stb;
  logic                                 o_wb_we;
  logic [WB_ADDR_WIDTH-1:0]             o_wb_addr;
  logic [WB_SEL_WIDTH-1:0]              o_wb_sel;
  logic [WB_DATA_WIDTH-1:0]             o_wb_wdata;
  logic                                 i_wb_ack;
  logic                                 i_wb_stall;
  logic [WB_DATA_WIDTH-1:0]             i_wb_rdata;

  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_sel, i_m_wdata,
    input  o_m_ack, o_m_stall, o_m_rdata
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel, o_wb_wdata,
    output i_wb_ack, i_wb_stall, i_wb_rdata
  );

  modport arbiter (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_sel, i_m_wdata,
    output o_m_ack, o_m_stall, o_m_rdata,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel, o_wb_wdata,
    input  i_wb_ack, i_wb_stall, i_wb_rdata
  );
endinterface

// File: rtl/matrix_wb_arbiter.sv
// Round-robin Wishbone pipelined arbiter for the matrix register file slave.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module matrix_wb_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int WB_DATA_WIDTH   = 32,
  parameter int REG_COUNT       = 8,
  parameter int WB_ADDR_WIDTH   = $clog2(REG_COUNT),
  parameter int WB_SEL_WIDTH    = WB_DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  matrix_wb_arbiter_if.arbiter   bus,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic                   o_timeout
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] GRANTED = 1'b1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 1 || MAX_OUTSTANDING < 1) begin : g_bad_cfg
    $error("matrix_wb_arbiter: unsupported parameter combination");
  end

  logic [0:0]             state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       g;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic                   found;
  logic [OUT_W-1:0]       outstanding;
  logic                   cur_cyc;
  logic                   full;
  logic                   raw_stb;
  logic                   beat;
  logic                   ack_hit;
  logic                   timeout_fire;
  logic [NUM_MASTERS-1:0] mask;

  always_comb begin
    g = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (o_grant[k]) g = IDX_W'(k);
    end
  end

  // Search starts just after the previous owner so a re-requesting owner yields.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_MASTERS);
      if (!found && bus.i_m_cyc[cand] && !mask[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign cur_cyc = (state == GRANTED) && bus.i_m_cyc[g];
  assign full    = (outstanding == OUT_W'(MAX_OUTSTANDING));
  assign raw_stb = cur_cyc && bus.i_m_stb[g] && !full;
  assign beat    = raw_stb && !bus.i_wb_stall;
  assign ack_hit = (state == GRANTED) && bus.i_wb_ack && (outstanding != '0);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_count;

  assign timeout_fire = cur_cyc && !beat && !bus.i_wb_ack
                        && (wd_count == WD_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout    = timeout_fire;

  // A timed-out master stays masked until it is seen with cyc low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_count <= '0;
      mask     <= '0;
    end else begin
      mask <= (mask & bus.i_m_cyc) | (timeout_fire ? o_grant : '0);
      if (!cur_cyc || beat || bus.i_wb_ack || timeout_fire)
        wd_count <= '0;
      else
        wd_count <= wd_count + WD_W'(1);
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign o_timeout    = 1'b0;
  assign mask         = '0;
`endif

  always_comb begin
    bus.o_wb_cyc   = cur_cyc && !timeout_fire;
    bus.o_wb_stb   = raw_stb && !timeout_fire;
    bus.o_wb_we    = 1'b0;
    bus.o_wb_addr  = '0;
    bus.o_wb_sel   = '0;
    bus.o_wb_wdata = '0;
    bus.o_m_stall  = '1;
    bus.o_m_ack    = '0;
    bus.o_m_rdata  = bus.i_wb_rdata;
    if (state == GRANTED) begin
      bus.o_wb_we    = bus.i_m_we[g];
      bus.o_wb_addr  = bus.i_m_addr[int'(g)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
      bus.o_wb_sel   = bus.i_m_sel[int'(g)*WB_SEL_WIDTH +: WB_SEL_WIDTH];
      bus.o_wb_wdata = bus.i_m_wdata[int'(g)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      bus.o_m_stall[g] = bus.i_wb_stall || full;
      bus.o_m_ack[g]   = ack_hit;
    end
  end

  // Dropping cyc with beats still in flight aborts: the count is discarded
  // so late acks from the slave are never forwarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      o_grant     <= '0;
      last_grant  <= IDX_W'(NUM_MASTERS - 1);
      outstanding <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            o_grant <= NUM_MASTERS'(1) << winner;
            state   <= GRANTED;
          end
        end
        GRANTED: begin
          if (timeout_fire || !bus.i_m_cyc[g]) begin
            state       <= IDLE;
            o_grant     <= '0;
            last_grant  <= g;
            outstanding <= '0;
          end else if (beat && !ack_hit) begin
            outstanding <= outstanding + OUT_W'(1);
          end else if (ack_hit && !beat) begin
            outstanding <= outstanding - OUT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_wb_arbiter.sv
// Directed self-checking bench for matrix_wb_arbiter (two masters, 8-cycle watchdog
// exercised when WB_ARB_TIMEOUT_EN is defined).
module tb_matrix_wb_arbiter;
  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int SW = 4;

  logic          clk;
  logic          reset;
  logic [NM-1:0] grant;
  logic          timeout;
  int            tests;
  int            fails;
  int            beats;

  matrix_wb_arbiter_if #(.NUM_MASTERS(NM), .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW)) bus ();

  matrix_wb_arbiter #(
    .NUM_MASTERS(NM), .WB_DATA_WIDTH(DW), .REG_COUNT(8), .WB_ADDR_WIDTH(AW),
    .WB_SEL_WIDTH(SW), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_grant(grant), .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.i_wb_ack = 1'b1;
    #3;
    tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL reset_grant got %b expected 00", grant); end
    tests++; if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || bus.o_wb_addr !== 3'd0 || bus.o_wb_wdata !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_wb got cyc=%b stb=%b addr=%0h wdata=%0h expected all 0", bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_addr, bus.o_wb_wdata);
    end
    tests++; if (bus.o_m_ack !== 2'b00 || bus.o_m_stall !== 2'b11 || timeout !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_master got ack=%b stall=%b timeout=%b expected 00 11 0", bus.o_m_ack, bus.o_m_stall, timeout);
    end
    bus.i_wb_ack = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_round_robin;
    bus.i_m_cyc = 2'b11;
    #1;
    tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL rr_latency got %b expected 00", grant); end
    tick;
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL rr_first got %b expected 01", grant); end
    bus.i_m_stb = 2'b01; bus.i_m_we = 2'b01;
    bus.i_m_addr = {3'd5, 3'd3}; bus.i_m_sel = {4'h0, 4'hF};
    bus.i_m_wdata = {32'h22222222, 32'h11111111};
    bus.i_wb_rdata = 32'hCAFE0001;
    #1;
    tests++; if (bus.o_wb_stb !== 1'b1 || bus.o_wb_we !== 1'b1 || bus.o_wb_addr !== 3'd3 || bus.o_wb_wdata !== 32'h11111111 || bus.o_wb_sel !== 4'hF) begin
      fails++; $display("[TB] FAIL rr_mux got stb=%b we=%b addr=%0d wdata=%h sel=%h expected 1 1 3 11111111 f", bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr, bus.o_wb_wdata, bus.o_wb_sel);
    end
    tests++; if (bus.o_m_stall !== 2'b10 || bus.o_m_rdata !== 32'hCAFE0001) begin
      fails++; $display("[TB] FAIL rr_stall_rdata got stall=%b rdata=%h expected 10 cafe0001", bus.o_m_stall, bus.o_m_rdata);
    end
    tick;
    bus.i_m_stb = 2'b00; bus.i_wb_ack = 1'b1;
    #1;
    tests++; if (bus.o_m_ack !== 2'b01) begin fails++; $display("[TB] FAIL rr_ack got %b expected 01", bus.o_m_ack); end
    tick;
    bus.i_wb_ack = 1'b0; bus.i_m_cyc = 2'b10; bus.i_m_we = 2'b00;
    #1;
    tests++; if (bus.o_wb_cyc !== 1'b0) begin fails++; $display("[TB] FAIL rr_release_cyc got %b expected 0", bus.o_wb_cyc); end
    tick;
    tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL rr_release_grant got %b expected 00", grant); end
    tick;
    tests++; if (grant !== 2'b10) begin fails++; $display("[TB] FAIL rr_second got %b expected 10", grant); end
    bus.i_m_cyc = 2'b00;
    tick;
    tick;
  endtask

  task automatic test_stall_and_full;
    bus.i_m_cyc = 2'b01; bus.i_m_stb = 2'b01; bus.i_wb_stall = 1'b1;
    tick;
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL stall_grant got %b expected 01", grant); end
    tick; tick; tick;
    tests++; if (bus.o_m_stall !== 2'b11 || bus.o_wb_stb !== 1'b1 || dut.outstanding !== 3'd0) begin
      fails++; $display("[TB] FAIL stall_hold got stall=%b stb=%b outstanding=%0d expected 11 1 0", bus.o_m_stall, bus.o_wb_stb, dut.outstanding);
    end
    bus.i_wb_stall = 1'b0;
    #1;
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_wb_stb && !bus.i_wb_stall) beats++;
      tick;
    end
    tests++; if (beats !== 4) begin fails++; $display("[TB] FAIL full_beats got %0d expected 4", beats); end
    tests++; if (bus.o_wb_stb !== 1'b0 || bus.o_m_stall !== 2'b11 || dut.outstanding !== 3'd4) begin
      fails++; $display("[TB] FAIL full_block got stb=%b stall=%b outstanding=%0d expected 0 11 4", bus.o_wb_stb, bus.o_m_stall, dut.outstanding);
    end
    bus.i_m_stb = 2'b00; bus.i_wb_ack = 1'b1;
    #1;
    tests++; if (bus.o_m_ack !== 2'b01) begin fails++; $display("[TB] FAIL full_ack got %b expected 01", bus.o_m_ack); end
    tick; tick;
    bus.i_m_stb = 2'b01;
    #1;
    tests++; if (bus.o_wb_stb !== 1'b1 || dut.outstanding !== 3'd2) begin
      fails++; $display("[TB] FAIL same_cycle_pre got stb=%b outstanding=%0d expected 1 2", bus.o_wb_stb, dut.outstanding);
    end
    tick;
    bus.i_m_stb = 2'b00; bus.i_wb_ack = 1'b0;
    #1;
    tests++; if (dut.outstanding !== 3'd2) begin fails++; $display("[TB] FAIL same_cycle_count got %0d expected 2", dut.outstanding); end
    bus.i_wb_ack = 1'b1;
    tick; tick;
    tests++; if (bus.o_m_ack !== 2'b00 || dut.outstanding !== 3'd0) begin
      fails++; $display("[TB] FAIL underflow got ack=%b outstanding=%0d expected 00 0", bus.o_m_ack, dut.outstanding);
    end
    bus.i_wb_ack = 1'b0; bus.i_m_cyc = 2'b00;
    tick;
    bus.i_wb_ack = 1'b1;
    #1;
    tests++; if (bus.o_m_ack !== 2'b00 || grant !== 2'b00) begin
      fails++; $display("[TB] FAIL stray_idle_ack got ack=%b grant=%b expected 00 00", bus.o_m_ack, grant);
    end
    tick;
    bus.i_wb_ack = 1'b0;
  endtask

  task automatic test_abort;
    bus.i_m_cyc = 2'b10; bus.i_m_stb = 2'b10; bus.i_wb_stall = 1'b0;
    tick;
    tests++; if (grant !== 2'b10) begin fails++; $display("[TB] FAIL abort_grant got %b expected 10", grant); end
    tick; tick; tick;
    bus.i_m_stb = 2'b00;
    #1;
    tests++; if (dut.outstanding !== 3'd3) begin fails++; $display("[TB] FAIL abort_inflight got %0d expected 3", dut.outstanding); end
    bus.i_m_cyc = 2'b00;
    #1;
    tests++; if (bus.o_wb_cyc !== 1'b0) begin fails++; $display("[TB] FAIL abort_cyc got %b expected 0", bus.o_wb_cyc); end
    tick;
    tests++; if (grant !== 2'b00 || dut.outstanding !== 3'd0 || dut.state !== 1'b0) begin
      fails++; $display("[TB] FAIL abort_idle got grant=%b outstanding=%0d state=%b expected 00 0 0", grant, dut.outstanding, dut.state);
    end
    bus.i_wb_ack = 1'b1;
    #1;
    tests++; if (bus.o_m_ack !== 2'b00) begin fails++; $display("[TB] FAIL abort_late_ack got %b expected 00", bus.o_m_ack); end
    tick;
    tests++; if (bus.o_m_ack !== 2'b00) begin fails++; $display("[TB] FAIL abort_late_ack2 got %b expected 00", bus.o_m_ack); end
    bus.i_wb_ack = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    bus.i_m_cyc = 2'b10; bus.i_m_stb = 2'b10;
    tick;
    tests++; if (grant !== 2'b10) begin fails++; $display("[TB] FAIL midrst_grant got %b expected 10", grant); end
    tick;
    reset = 1'b0;
    #1;
    tests++; if (grant !== 2'b00 || bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || bus.o_m_stall !== 2'b11 || dut.outstanding !== 3'd0) begin
      fails++; $display("[TB] FAIL midrst_async got grant=%b cyc=%b stb=%b stall=%b outstanding=%0d expected 00 0 0 11 0", grant, bus.o_wb_cyc, bus.o_wb_stb, bus.o_m_stall, dut.outstanding);
    end
    bus.i_wb_ack = 1'b1;
    #1;
    tests++; if (bus.o_m_ack !== 2'b00) begin fails++; $display("[TB] FAIL midrst_ack got %b expected 00", bus.o_m_ack); end
    bus.i_wb_ack = 1'b0; bus.i_m_stb = 2'b00; bus.i_m_cyc = 2'b11;
    #1;
    reset = 1'b1;
    tick;
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL midrst_first got %b expected 01", grant); end
    bus.i_m_cyc = 2'b00;
    tick; tick;
  endtask

  task automatic test_timeout;
    bus.i_m_cyc = 2'b01; bus.i_m_stb = 2'b01; bus.i_wb_stall = 1'b1;
    tick;
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL wd_grant got %b expected 01", grant); end
    bus.i_m_cyc = 2'b11;
`ifdef WB_ARB_TIMEOUT_EN
    #1;
    for (int i = 1; i <= 8; i++) begin
      tests++; if (timeout !== (i == 8)) begin fails++; $display("[TB] FAIL wd_pulse cycle %0d got %b expected %b", i, timeout, (i == 8)); end
      if (i == 8) begin
        tests++; if (bus.o_wb_cyc !== 1'b0) begin fails++; $display("[TB] FAIL wd_force_cyc got %b expected 0", bus.o_wb_cyc); end
      end
      tick;
    end
    tests++; if (grant !== 2'b00 || timeout !== 1'b0) begin fails++; $display("[TB] FAIL wd_release got grant=%b timeout=%b expected 00 0", grant, timeout); end
    tick;
    tests++; if (grant !== 2'b10) begin fails++; $display("[TB] FAIL wd_move got %b expected 10", grant); end
    bus.i_m_cyc = 2'b01;
    tick; tick;
    tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL wd_masked got %b expected 00", grant); end
    bus.i_m_cyc = 2'b00;
    tick;
    bus.i_m_cyc = 2'b01;
    tick;
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL wd_unmask got %b expected 01", grant); end
`else
    for (int i = 0; i < 12; i++) tick;
    tests++; if (grant !== 2'b01 || timeout !== 1'b0 || bus.o_wb_cyc !== 1'b1) begin
      fails++; $display("[TB] FAIL wd_disabled got grant=%b timeout=%b cyc=%b expected 01 0 1", grant, timeout, bus.o_wb_cyc);
    end
`endif
    bus.i_m_cyc = 2'b00; bus.i_m_stb = 2'b00; bus.i_wb_stall = 1'b0;
    tick; tick;
  endtask

  initial begin
    tests = 0; fails = 0; beats = 0;
    reset = 1'b0;
    bus.i_m_cyc = '0; bus.i_m_stb = '0; bus.i_m_we = '0;
    bus.i_m_addr = '0; bus.i_m_sel = '0; bus.i_m_wdata = '0;
    bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0; bus.i_wb_rdata = '0;
    tick;
    test_reset;
    test_round_robin;
    test_stall_and_full;
    test_abort;
    test_reset_mid_burst;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
